// File: rtl/ena_seq_pkg.sv
// Shared types and defaults for the clkB enable sequencer.
// Optional abort behaviour is enabled with ENA_SEQ_ABORT_EN.
package ena_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NREQ_DEF    = 4;
    localparam int NSTAGE_DEF  = 4;
    localparam int DWELL_W_DEF = 4;

    // Index width for n items, never narrower than one bit
    function automatic int step_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ena_sequencer_rr_arbiter.sv
// Round-robin pick: first requester at or after the pointer.
// Purely combinational; the sequencer registers the result.
module rr_arbiter
    import ena_seq_pkg::*;
#(
    parameter int  NREQ = NREQ_DEF,
    localparam int PW   = step_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   pointer,
    output logic [NREQ-1:0] pick
);

    logic [PW-1:0] idx;

    // Scan from farthest to nearest so the nearest hit wins
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = PW'((int'(pointer) + k) % NREQ);
            if (req[idx]) begin
                pick      = '0;
                pick[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ena_sequencer.sv
// Staggered stage-enable sequencer shared by round-robin requesters.
// Define ENA_SEQ_ABORT_EN to let a dropped request abort its sequence.
module ena_sequencer
    import ena_seq_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int NSTAGE  = NSTAGE_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clkB,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [DWELL_W-1:0] dwell,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    ack,
    output logic               busy,
    output logic [NSTAGE-1:0]  ena
);

    localparam int SW = step_w(NSTAGE);
    localparam int PW = step_w(NREQ);

    state_e             state_q, state_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic [NREQ-1:0]    ack_q, ack_d;
    logic               busy_q, busy_d;
    logic [NSTAGE-1:0]  ena_q, ena_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [SW-1:0]      step_q, step_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;

    logic [NREQ-1:0] pick;
    logic [PW-1:0]   gidx;
    logic [PW-1:0]   ptr_nxt;
    logic            tc;
    logic            last_step;
    logic            abort;

    function automatic logic [NSTAGE-1:0] ena_mask(input logic [SW-1:0] s);
        logic [NSTAGE-1:0] m;
        for (int i = 0; i < NSTAGE; i++) begin
            m[i] = (SW'(i) >= s);
        end
        return m;
    endfunction

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req     (req),
        .pointer (ptr_q),
        .pick    (pick)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) gidx = PW'(i);
        end
    end

    assign ptr_nxt   = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
    assign tc        = (cnt_q == dwell_q);
    assign last_step = (step_q == SW'(NSTAGE - 1));

`ifdef ENA_SEQ_ABORT_EN
    assign abort = ~|(req & grant_q);
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ack_d   = '0;
        busy_d  = busy_q;
        ena_d   = ena_q;
        ptr_d   = ptr_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = STEP;
                    grant_d = pick;
                    busy_d  = 1'b1;
                    ena_d   = '1;
                    step_d  = '0;
                    cnt_d   = '0;
                    dwell_d = dwell;
                end
            end
            STEP: begin
                if (abort) begin
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ena_d   = '0;
                    ptr_d   = ptr_nxt;
                    step_d  = '0;
                    cnt_d   = '0;
                end else if (tc) begin
                    cnt_d = '0;
                    if (last_step) begin
                        state_d = DONE;
                        ena_d   = '0;
                        ack_d   = grant_q;
                    end else begin
                        step_d = step_q + 1'b1;
                        ena_d  = ena_mask(step_d);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                ptr_d   = ptr_nxt;
                step_d  = '0;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                ena_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clkB or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            ena_q   <= '0;
            ptr_q   <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            ena_q   <= ena_d;
            ptr_q   <= ptr_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
        end
    end

    assign grant = grant_q;
    assign ack   = ack_q;
    assign busy  = busy_q;
    assign ena   = ena_q;

endmodule
